cxs_tx_packer: RTL and testbench

// Parametrised CXS transmit-side width packer with credit flow control and link activation.

---
 rtl/cxs_tx_packer_if.sv | 38 +++
 rtl/cxs_tx_packer.sv | 141 ++++++++++++++
 tb/tb_cxs_tx_packer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cxs_tx_packer_if.sv
// Bundled upstream CXS and downstream packet signals of the CXS transmit packer.
// slave is the packer's view; master is the driving environment's view.
interface cxs_tx_packer_if #(
  parameter int IN_W    = 256,
  parameter int RATIO   = 2,
  parameter int CNTL_W  = 14,
  parameter int MAX_CRD = 8
);
  logic                           activereq;
  logic                           activeack;
  logic                           deacthint;
  logic                           crdgnt;
  logic                           crdrtn;
  logic                           valid;
  logic                           last;
  logic [IN_W-1:0]                data;
  logic [CNTL_W-1:0]              cntl;
  logic                           rx_ready;
  logic                           tx_pkt_vld;
  logic                           tx_pkt_rdy;
  logic [IN_W*RATIO-1:0]          tx_pkt_data;
  logic [$clog2(RATIO+1)-1:0]     tx_pkt_beats;
  logic [CNTL_W-1:0]              tx_pkt_cntl;
  logic [$clog2(MAX_CRD+1)-1:0]   crd_outstanding;
  logic                           err_nocrd;

  modport slave (
    input  activereq, crdrtn, valid, last, data, cntl, rx_ready, tx_pkt_rdy,
    output activeack, deacthint, crdgnt, tx_pkt_vld, tx_pkt_data, tx_pkt_beats,
           tx_pkt_cntl, crd_outstanding, err_nocrd
  );

  modport master (
    output activereq, crdrtn, valid, last, data, cntl, rx_ready, tx_pkt_rdy,
    input  activeack, deacthint, crdgnt, tx_pkt_vld, tx_pkt_data, tx_pkt_beats,
           tx_pkt_cntl, crd_outstanding, err_nocrd
  );
endinterface

// File: rtl/cxs_tx_packer.sv
// CXS beat-to-packet width packer with credit grant/return, activation FSM and packet FIFO.
// Packet visible one cycle after its closing beat; head held while tx_pkt_rdy is low, credits throttle input.
module cxs_tx_packer #(
  parameter int IN_W       = 256,
  parameter int RATIO      = 2,
  parameter int CNTL_W     = 14,
  parameter int MAX_CRD    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic            cxs_clk_i,
  input logic            cxs_rst_i,
  cxs_tx_packer_if.slave cxs
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int BW    = $clog2(RATIO + 1);
  localparam int CRW   = $clog2(MAX_CRD + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FCW   = AW + 1;

  typedef enum logic [1:0] {ST_STOP, ST_ACT, ST_RUN, ST_DEACT} state_e;

  state_e             state_q, state_d;
  logic               ack_q, hint_q, err_q;
  logic [CRW-1:0]     crd_q, crd_d;
  logic [BW-1:0]      pack_cnt_q;
  logic [OUT_W-1:0]   pack_data_q, pack_asm;
  logic [CNTL_W-1:0]  pack_cntl_q, first_cntl;

  logic [OUT_W-1:0]   fifo_data_q  [FIFO_DEPTH];
  logic [BW-1:0]      fifo_beats_q [FIFO_DEPTH];
  logic [CNTL_W-1:0]  fifo_cntl_q  [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]     fifo_cnt_q;

  logic               beat_acc, close_w, gnt_w, pop_w;
  logic [31:0]        occ, crd_sum;

  // Reserve a FIFO slot per outstanding credit so every beat can close its own packet.
  always_comb begin
    occ      = 32'(crd_q) + 32'(fifo_cnt_q) + 32'(pack_cnt_q != '0);
    gnt_w    = (state_q == ST_RUN) && (32'(crd_q) < MAX_CRD) && (occ < FIFO_DEPTH);
    beat_acc = cxs.valid && (crd_q != '0) && ((state_q == ST_RUN) || (state_q == ST_DEACT));
    close_w  = beat_acc && ((pack_cnt_q == BW'(RATIO - 1)) || cxs.last);
    pop_w    = (fifo_cnt_q != '0) && cxs.tx_pkt_rdy;
    crd_sum  = 32'(crd_q) + 32'(gnt_w) - 32'(beat_acc);
    if (cxs.crdrtn && (crd_sum != 32'd0)) begin
      crd_sum = crd_sum - 32'd1;
    end
    crd_d = CRW'(crd_sum);
  end

  always_comb begin
    pack_asm = pack_data_q;
    for (int k = 0; k < RATIO; k++) begin
      if (pack_cnt_q == BW'(k)) begin
        pack_asm[k*IN_W +: IN_W] = cxs.data;
      end
    end
    first_cntl = (pack_cnt_q == '0) ? cxs.cntl : pack_cntl_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (cxs.activereq && cxs.rx_ready) state_d = ST_ACT;
      ST_ACT:   state_d = ST_RUN;
      ST_RUN:   if (!cxs.activereq) state_d = ST_DEACT;
      ST_DEACT: if ((crd_q == '0) && (pack_cnt_q == '0)) state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge cxs_clk_i or posedge cxs_rst_i) begin
    if (cxs_rst_i) begin
      state_q <= ST_STOP;
      ack_q   <= 1'b0;
      hint_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_RUN) || (state_d == ST_DEACT);
      hint_q  <= (state_q == ST_RUN) && !cxs.rx_ready;
    end
  end

  always_ff @(posedge cxs_clk_i or posedge cxs_rst_i) begin
    if (cxs_rst_i) begin
      crd_q       <= '0;
      err_q       <= 1'b0;
      pack_cnt_q  <= '0;
      pack_data_q <= '0;
      pack_cntl_q <= '0;
    end else begin
      crd_q <= crd_d;
      err_q <= err_q | (cxs.valid && (crd_q == '0));
      if (beat_acc) begin
        if (close_w) begin
          pack_cnt_q  <= '0;
          pack_data_q <= '0;
        end else begin
          pack_cnt_q  <= pack_cnt_q + BW'(1);
          pack_data_q <= pack_asm;
        end
        pack_cntl_q <= first_cntl;
      end
    end
  end

  always_ff @(posedge cxs_clk_i or posedge cxs_rst_i) begin
    if (cxs_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_beats_q[i] <= '0;
        fifo_cntl_q[i]  <= '0;
      end
    end else begin
      if (close_w) begin
        fifo_data_q[wr_ptr_q]  <= pack_asm;
        fifo_beats_q[wr_ptr_q] <= pack_cnt_q + BW'(1);
        fifo_cntl_q[wr_ptr_q]  <= first_cntl;
        wr_ptr_q               <= wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + FCW'(close_w) - FCW'(pop_w);
    end
  end

  assign cxs.activeack       = ack_q;
  assign cxs.deacthint       = hint_q;
  assign cxs.crdgnt          = gnt_w;
  assign cxs.crd_outstanding = crd_q;
  assign cxs.err_nocrd       = err_q;
  assign cxs.tx_pkt_vld      = (fifo_cnt_q != '0);
  assign cxs.tx_pkt_data     = fifo_data_q[rd_ptr_q];
  assign cxs.tx_pkt_beats    = fifo_beats_q[rd_ptr_q];
  assign cxs.tx_pkt_cntl     = fifo_cntl_q[rd_ptr_q];
endmodule

// File: tb/tb_cxs_tx_packer.sv
// Bench for cxs_tx_packer: directed activation/credit/packing cases plus random traffic,
// with a queue scoreboard fed by a beat-level packing model and a separate output monitor.
module tb_cxs_tx_packer;
  localparam int IN_W       = 256;
  localparam int RATIO      = 2;
  localparam int CNTL_W     = 14;
  localparam int MAX_CRD    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int OUT_W      = IN_W * RATIO;

  typedef struct {
    logic [OUT_W-1:0]  data;
    int                beats;
    logic [CNTL_W-1:0] cntl;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cxs_tx_packer_if #(.IN_W(IN_W), .RATIO(RATIO), .CNTL_W(CNTL_W), .MAX_CRD(MAX_CRD)) bus ();

  cxs_tx_packer #(
    .IN_W(IN_W), .RATIO(RATIO), .CNTL_W(CNTL_W), .MAX_CRD(MAX_CRD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .cxs_clk_i (clk),
    .cxs_rst_i (rst),
    .cxs       (bus.slave)
  );

  int                n_vec = 0;
  int                n_bad = 0;
  pkt_t              exp_q[$];
  logic [IN_W-1:0]   cur_beats[$];
  logic [CNTL_W-1:0] cur_cntl;
  int                crd_model = 0;
  logic              stall_prev = 1'b0;
  logic [OUT_W-1:0]  prev_data;
  int                prev_beats;
  int                prev_cntl;
  pkt_t              e, p;
  int                fifo_now, nxt;
  logic              acc;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor + reference model: checks the current cycle, then predicts the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_beats.delete();
      crd_model  = 0;
      stall_prev = 1'b0;
    end else begin
      fifo_now = exp_q.size();
      if (stall_prev) begin
        chk("hold_vld", int'(bus.tx_pkt_vld), 1);
        chkd("hold_data", bus.tx_pkt_data, prev_data);
        chk("hold_beats", int'(bus.tx_pkt_beats), prev_beats);
        chk("hold_cntl", int'(bus.tx_pkt_cntl), prev_cntl);
      end
      if (bus.tx_pkt_vld && bus.tx_pkt_rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pkt: got data %0h expected no packet", bus.tx_pkt_data);
        end else begin
          e = exp_q.pop_front();
          chkd("pkt_data", bus.tx_pkt_data, e.data);
          chk("pkt_beats", int'(bus.tx_pkt_beats), e.beats);
          chk("pkt_cntl", int'(bus.tx_pkt_cntl), int'(e.cntl));
        end
      end
      chk("crd_outstanding", int'(bus.crd_outstanding), crd_model);
      if (bus.crdgnt) begin
        chk("gnt_bound", int'((crd_model < MAX_CRD) &&
            (crd_model + fifo_now + int'(cur_beats.size() != 0) < FIFO_DEPTH)), 1);
      end
      acc = bus.valid && (crd_model != 0);
      nxt = crd_model + int'(bus.crdgnt) - int'(acc);
      if (bus.crdrtn && nxt > 0) nxt = nxt - 1;
      crd_model = nxt;
      if (acc) begin
        if (cur_beats.size() == 0) cur_cntl = bus.cntl;
        cur_beats.push_back(bus.data);
        if (cur_beats.size() == RATIO || bus.last) begin
          p.data = '0;
          for (int k = 0; k < cur_beats.size(); k++) p.data[k*IN_W +: IN_W] = cur_beats[k];
          p.beats = cur_beats.size();
          p.cntl  = cur_cntl;
          exp_q.push_back(p);
          cur_beats.delete();
        end
      end
      stall_prev = bus.tx_pkt_vld && !bus.tx_pkt_rdy;
      prev_data  = bus.tx_pkt_data;
      prev_beats = int'(bus.tx_pkt_beats);
      prev_cntl  = int'(bus.tx_pkt_cntl);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rnd_beat();
    logic [IN_W-1:0] b;
    for (int i = 0; i < IN_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic send(input logic [IN_W-1:0] d, input logic [CNTL_W-1:0] c, input logic l);
    int w = 0;
    while (crd_model == 0 && w < 40) begin
      cyc();
      w++;
    end
    if (crd_model == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: no credit after %0d cycles, expected at least 1", w);
    end else begin
      bus.valid = 1'b1;
      bus.data  = d;
      bus.cntl  = c;
      bus.last  = l;
      cyc();
      bus.valid = 1'b0;
      bus.last  = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    bus.tx_pkt_rdy = 1'b1;
    while ((exp_q.size() != 0 || bus.tx_pkt_vld) && w < 60) begin
      cyc();
      w++;
    end
    chk("drain_vld", int'(bus.tx_pkt_vld), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int gcnt;
    int w;
    bus.activereq = 1'b0; bus.crdrtn = 1'b0; bus.valid = 1'b0; bus.last = 1'b0;
    bus.data = '0; bus.cntl = '0; bus.rx_ready = 1'b0; bus.tx_pkt_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(bus.activeack), 0);
    chk("rst_gnt", int'(bus.crdgnt), 0);
    chk("rst_vld", int'(bus.tx_pkt_vld), 0);
    chk("rst_crd", int'(bus.crd_outstanding), 0);
    chk("rst_err", int'(bus.err_nocrd), 0);
    chk("rst_hint", int'(bus.deacthint), 0);
    cyc();
    rst = 1'b0;

    // Activation held off while the link is not ready.
    bus.activereq = 1'b1;
    repeat (5) begin
      cyc();
      @(negedge clk);
      chk("t1_ack_held", int'(bus.activeack), 0);
      chk("t1_no_gnt", int'(bus.crdgnt), 0);
    end
    cyc();
    bus.rx_ready = 1'b1;
    @(negedge clk); chk("t1_ack_c0", int'(bus.activeack), 0);
    cyc(); @(negedge clk); chk("t1_ack_c1", int'(bus.activeack), 0);
    cyc(); @(negedge clk); chk("t1_ack_c2", int'(bus.activeack), 1);

    // Credit grants with a blocked output stop at the FIFO depth.
    gcnt = int'(bus.crdgnt);
    repeat (11) begin
      cyc();
      @(negedge clk);
      gcnt += int'(bus.crdgnt);
    end
    chk("t2_gnt_count", gcnt, FIFO_DEPTH);
    chk("t2_crd", int'(bus.crd_outstanding), FIFO_DEPTH);
    chk("t2_hint_low", int'(bus.deacthint), 0);

    cyc(); bus.rx_ready = 1'b0;
    @(negedge clk); chk("hint_lag", int'(bus.deacthint), 0);
    cyc(); bus.rx_ready = 1'b1;
    @(negedge clk); chk("hint_set", int'(bus.deacthint), 1);
    cyc();
    @(negedge clk); chk("hint_clr", int'(bus.deacthint), 0);
    cyc();

    send(256'h10, 14'h10, 1'b0);
    send(256'h20, 14'h55, 1'b0);
    @(negedge clk);
    chk("t3_vld", int'(bus.tx_pkt_vld), 1);
    chkd("t3_data", bus.tx_pkt_data, {256'h20, 256'h10});
    chk("t3_beats", int'(bus.tx_pkt_beats), 2);
    chk("t3_cntl", int'(bus.tx_pkt_cntl), 'h10);
    cyc();

    send(256'h30, 14'h3, 1'b1);
    send(256'h40, 14'h7, 1'b0);
    send(256'h50, 14'h8, 1'b1);
    repeat (3) cyc();
    drain();

    // Random traffic with random backpressure, lasts and credit returns.
    repeat (400) begin
      bus.tx_pkt_rdy = ($urandom_range(0, 3) != 0);
      if (crd_model > 0 && $urandom_range(0, 1) == 1) begin
        bus.valid = 1'b1;
        bus.data  = rnd_beat();
        bus.cntl  = CNTL_W'($urandom);
        bus.last  = ($urandom_range(0, 3) == 0);
      end else begin
        bus.valid = 1'b0;
        bus.last  = 1'b0;
      end
      bus.crdrtn = ($urandom_range(0, 15) == 0);
      cyc();
    end
    bus.valid  = 1'b0;
    bus.last   = 1'b0;
    bus.crdrtn = 1'b0;
    send(rnd_beat(), CNTL_W'($urandom), 1'b1);
    drain();
    repeat (10) cyc();
    chk("rand_no_err", int'(bus.err_nocrd), 0);

    // Deactivation waits for outstanding credits to come back.
    bus.activereq = 1'b0;
    repeat (3) cyc();
    @(negedge clk); chk("t5_ack_deact", int'(bus.activeack), 1);
    cyc();
    w = 0;
    while (crd_model > 2 && w < 12) begin
      bus.crdrtn = 1'b1;
      cyc();
      w++;
    end
    bus.crdrtn = 1'b0;
    @(negedge clk);
    chk("t5_crd2", int'(bus.crd_outstanding), 2);
    chk("t5_ack_still", int'(bus.activeack), 1);
    cyc();
    bus.crdrtn = 1'b1;
    cyc(); cyc();
    bus.crdrtn = 1'b0;
    w = 0;
    while (bus.activeack && w < 8) begin
      cyc();
      w++;
    end
    chk("t5_ack_drop", int'(bus.activeack), 0);
    chk("t5_crd0", int'(bus.crd_outstanding), 0);

    // Beat without credit is dropped and flagged; reset clears everything.
    bus.valid = 1'b1; bus.data = 256'hbad; bus.last = 1'b1;
    cyc();
    bus.valid = 1'b0; bus.last = 1'b0;
    @(negedge clk); chk("t6_err_set", int'(bus.err_nocrd), 1);
    repeat (5) cyc();
    @(negedge clk);
    chk("t6_err_sticky", int'(bus.err_nocrd), 1);
    chk("t6_no_pkt", int'(bus.tx_pkt_vld), 0);
    cyc();
    bus.activereq = 1'b1;
    send(256'h61, 14'h1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ack", int'(bus.activeack), 0);
    chk("t6_rst_crd", int'(bus.crd_outstanding), 0);
    chk("t6_rst_err", int'(bus.err_nocrd), 0);
    chk("t6_rst_vld", int'(bus.tx_pkt_vld), 0);
    chk("t6_rst_gnt", int'(bus.crdgnt), 0);
    cyc();
    rst = 1'b0;
    send(256'h71, 14'h2, 1'b0);
    send(256'h72, 14'h3, 1'b0);
    @(negedge clk);
    chkd("t6_post_rst_data", bus.tx_pkt_data, {256'h72, 256'h71});
    cyc();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
